// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational ALU, one operation in flight.
// Sequence per operation: IDLE (grant) -> EXEC (ALU driven, result captured) -> HOLD (response).
// Optional build macro: ALU_ARB_FIXED_PRIO_EN makes port 0 win every simultaneous request.
// Without it, a round-robin pointer starts at RESET_PTR.
//
// Handshake rules:
//   A request transfers in a cycle where both reqN_valid and reqN_ready are high.
//   reqN_ready is high only in IDLE.
//   A requester holds valid and payload stable until it sees ready.
//   A response transfers in a cycle where both rspN_valid and rspN_ready are high.
//   rspN_valid and rspN_data stay stable until that transfer happens.
//   rspN_ready is ignored while rspN_valid is low.
module alu_arbiter #(
  parameter logic RESET_PTR = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [8:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [8:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic [31:0] alu1_data,
  output logic [31:0] alu2_data,
  output logic [2:0]  alu_funct3,
  output logic [4:0]  alu_funct5,
  output logic        alu_bit30,
  input  logic [31:0] alu_result,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q;
  logic        gnt_id_q;
  logic [31:0] alu1_q;
  logic [31:0] alu2_q;
  logic [2:0]  funct3_q;
  logic [4:0]  funct5_q;
  logic        bit30_q;
  logic        rsp0_valid_q;
  logic        rsp1_valid_q;
  logic [31:0] rsp0_data_q;
  logic [31:0] rsp1_data_q;
  logic        gnt0;
  logic        gnt1;
  logic        rsp_done;
  logic        sel_ptr;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Port 0 always wins a simultaneous request; no pointer state exists.
  assign sel_ptr = 1'b0;
`else
  logic ptr_q;

  // Round-robin pointer: after each grant it points at the port that was not granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= RESET_PTR;
    end else if (gnt0 || gnt1) begin
      ptr_q <= gnt0;
    end
  end

  assign sel_ptr = ptr_q;
`endif

  // Grant decision: only in IDLE; a lone request wins, a tie goes to sel_ptr.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt0 = ~sel_ptr;
        gnt1 = sel_ptr;
      end else if (req0_valid) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  // The response completes when the granted port consumes it.
  assign rsp_done = gnt_id_q ? rsp1_ready : rsp0_ready;

  // Operation FSM: latch the payload on grant, capture the ALU result in EXEC,
  // and hold the response until it is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_id_q     <= 1'b0;
      alu1_q       <= '0;
      alu2_q       <= '0;
      funct3_q     <= '0;
      funct5_q     <= '0;
      bit30_q      <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt0 || gnt1) begin
            state_q  <= EXEC;
            gnt_id_q <= gnt1;
            alu1_q   <= gnt1 ? req1_a : req0_a;
            alu2_q   <= gnt1 ? req1_b : req0_b;
            bit30_q  <= gnt1 ? req1_op[8] : req0_op[8];
            funct5_q <= gnt1 ? req1_op[7:3] : req0_op[7:3];
            funct3_q <= gnt1 ? req1_op[2:0] : req0_op[2:0];
          end
        end
        EXEC: begin
          state_q      <= HOLD;
          rsp0_valid_q <= ~gnt_id_q;
          rsp1_valid_q <= gnt_id_q;
          rsp0_data_q  <= gnt_id_q ? 32'd0 : alu_result;
          rsp1_data_q  <= gnt_id_q ? alu_result : 32'd0;
          // Shared ALU inputs return to zero outside EXEC.
          alu1_q       <= '0;
          alu2_q       <= '0;
          funct3_q     <= '0;
          funct5_q     <= '0;
          bit30_q      <= 1'b0;
        end
        HOLD: begin
          if (rsp_done) begin
            state_q      <= IDLE;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign alu1_data  = alu1_q;
  assign alu2_data  = alu2_q;
  assign alu_funct3 = funct3_q;
  assign alu_funct5 = funct5_q;
  assign alu_bit30  = bit30_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter.
// Directed vector table for single operations.
// Hand-written sequences cover simultaneous requests, a stalled response,
// and reset arriving during EXEC.
module tb_alu_arbiter;

  localparam logic [8:0] OP_ADD  = 9'b0_01100_000;
  localparam logic [8:0] OP_SUB  = 9'b1_01100_000;
  localparam logic [8:0] OP_SLL  = 9'b0_01100_001;
  localparam logic [8:0] OP_SLT  = 9'b0_01100_010;
  localparam logic [8:0] OP_SLTU = 9'b0_01100_011;
  localparam logic [8:0] OP_XOR  = 9'b0_01100_100;
  localparam logic [8:0] OP_SRL  = 9'b0_01100_101;
  localparam logic [8:0] OP_SRA  = 9'b1_01100_101;
  localparam logic [8:0] OP_AND  = 9'b0_01100_111;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [8:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [8:0]  req1_op;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [31:0] rsp0_data;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp1_data;
  logic [31:0] alu1_data;
  logic [31:0] alu2_data;
  logic [2:0]  alu_funct3;
  logic [4:0]  alu_funct5;
  logic        alu_bit30;
  logic [31:0] alu_result;
  logic [1:0]  state_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        port;
    logic [31:0] a;
    logic [31:0] b;
    logic [8:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  alu_arbiter #(.RESET_PTR(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .alu1_data  (alu1_data),
    .alu2_data  (alu2_data),
    .alu_funct3 (alu_funct3),
    .alu_funct5 (alu_funct5),
    .alu_bit30  (alu_bit30),
    .alu_result (alu_result),
    .state_o    (state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared combinational ALU (RV32 OP subset)
  always_comb begin
    alu_result = 32'd0;
    case (alu_funct3)
      3'b000: alu_result = alu_bit30 ? alu1_data - alu2_data : alu1_data + alu2_data;
      3'b001: alu_result = alu1_data << alu2_data[4:0];
      3'b010: alu_result = ($signed(alu1_data) < $signed(alu2_data)) ? 32'd1 : 32'd0;
      3'b011: alu_result = (alu1_data < alu2_data) ? 32'd1 : 32'd0;
      3'b100: alu_result = alu1_data ^ alu2_data;
      3'b101: alu_result = alu_bit30 ? $unsigned($signed(alu1_data) >>> alu2_data[4:0])
                                     : alu1_data >> alu2_data[4:0];
      3'b110: alu_result = alu1_data | alu2_data;
      default: alu_result = alu1_data & alu2_data;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input logic p);
    return p ? req1_ready : req0_ready;
  endfunction

  function automatic logic rv(input logic p);
    return p ? rsp1_valid : rsp0_valid;
  endfunction

  function automatic logic [31:0] rd(input logic p);
    return p ? rsp1_data : rsp0_data;
  endfunction

  // Driver tasks
  task automatic set_req(input logic p, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [8:0] op);
    if (p) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  task automatic set_rsp_ready(input logic p, input logic r);
    if (p) rsp1_ready = r;
    else   rsp0_ready = r;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 9'd0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 9'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete operation on a single port.
  // Called just after a negedge with the DUT in IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    set_req(v.port, 1'b1, v.a, v.b, v.op);
    #1;
    check($sformatf("v%0d ready", idx), {31'd0, rdy(v.port)}, 32'd1);
    check($sformatf("v%0d other_ready", idx), {31'd0, rdy(~v.port)}, 32'd0);
    @(negedge clk);
    set_req(v.port, 1'b0, 32'd0, 32'd0, 9'd0);
    #1;
    check($sformatf("v%0d alu1", idx), alu1_data, v.a);
    check($sformatf("v%0d alu2", idx), alu2_data, v.b);
    check($sformatf("v%0d alu_op", idx), {23'd0, alu_bit30, alu_funct5, alu_funct3}, {23'd0, v.op});
    check($sformatf("v%0d exec_rsp_valid", idx), {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    @(negedge clk);
    #1;
    check($sformatf("v%0d rsp_valid", idx), {31'd0, rv(v.port)}, 32'd1);
    check($sformatf("v%0d rsp_data", idx), rd(v.port), v.exp);
    check($sformatf("v%0d other_rsp", idx), {31'd0, rv(~v.port)}, 32'd0);
    check($sformatf("v%0d other_data", idx), rd(~v.port), 32'd0);
    check($sformatf("v%0d hold_alu1", idx), alu1_data, 32'd0);
    set_rsp_ready(v.port, 1'b1);
    @(negedge clk);
    #1;
    check($sformatf("v%0d rsp_cleared", idx), {31'd0, rv(v.port)}, 32'd0);
    check($sformatf("v%0d back_idle", idx), {30'd0, state_o}, 32'd0);
    set_rsp_ready(v.port, 1'b0);
  endtask

  initial begin
    logic exp_port;
    vecs[0] = '{1'b0, 32'd5,        32'd3,        OP_ADD,  32'd8};
    vecs[1] = '{1'b1, 32'd10,       32'd3,        OP_SUB,  32'd7};
    vecs[2] = '{1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, OP_XOR,  32'hFF00FF00};
    vecs[3] = '{1'b1, 32'd1,        32'd4,        OP_SLL,  32'd16};
    vecs[4] = '{1'b0, 32'h80000000, 32'd4,        OP_SRA,  32'hF8000000};
    vecs[5] = '{1'b1, 32'h80000000, 32'd4,        OP_SRL,  32'h08000000};
    vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'd1,        OP_SLT,  32'd1};
    vecs[7] = '{1'b1, 32'hFFFFFFFF, 32'd1,        OP_SLTU, 32'd0};
    vecs[8] = '{1'b0, 32'hFFFFFFFF, 32'd1,        OP_ADD,  32'd0};
    vecs[9] = '{1'b1, 32'h12345678, 32'h0000FFFF, OP_AND,  32'h00005678};

    // Outputs while reset is held low
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 9'd0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 9'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst state", {30'd0, state_o}, 32'd0);
    check("rst readys", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("rst rsp_valids", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("rst rsp_data", rsp0_data | rsp1_data, 32'd0);
    check("rst alu", alu1_data | alu2_data | {24'd0, alu_bit30, alu_funct5, alu_funct3}, 32'd0);
    rst_n = 1'b1;

    // IDLE with no requests; a stray rsp_ready must be ignored
    rsp0_ready = 1'b1;
    @(negedge clk);
    #1;
    check("idle readys", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("idle stray rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("idle state", {30'd0, state_o}, 32'd0);
    rsp0_ready = 1'b0;

    // Table-driven single operations
    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], i);
    end

    // Both ports request continuously, responses always consumed
    @(negedge clk);
    apply_reset();
    set_req(1'b0, 1'b1, 32'd7, 32'd2, OP_ADD);
    set_req(1'b1, 1'b1, 32'd7, 32'd2, OP_SUB);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_port = 1'b0;
`else
      exp_port = ((i / 3) % 2) != 0;
`endif
      if ((i % 3) == 0) begin
        check($sformatf("both c%0d readys", i), {30'd0, req1_ready, req0_ready},
              exp_port ? 32'd2 : 32'd1);
      end else begin
        check($sformatf("both c%0d readys_low", i), {30'd0, req1_ready, req0_ready}, 32'd0);
      end
      if ((i % 3) == 2) begin
        check($sformatf("both c%0d rsp_valids", i), {30'd0, rsp1_valid, rsp0_valid},
              exp_port ? 32'd2 : 32'd1);
        check($sformatf("both c%0d rsp_data", i), rd(exp_port), exp_port ? 32'd5 : 32'd9);
      end else begin
        check($sformatf("both c%0d rsp_low", i), {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      end
      @(negedge clk);
    end
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 9'd0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 9'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    // Stalled response on port 1 while port 0 waits
    apply_reset();
    set_req(1'b1, 1'b1, 32'd100, 32'd23, OP_ADD);
    #1;
    check("stall grant1", {30'd0, req1_ready, req0_ready}, 32'd2);
    @(negedge clk);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 9'd0);
    set_req(1'b0, 1'b1, 32'd1, 32'd2, OP_ADD);
    #1;
    check("stall exec ready0", {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("stall h%0d rsp1_valid", i), {31'd0, rsp1_valid}, 32'd1);
      check($sformatf("stall h%0d rsp1_data", i), rsp1_data, 32'd123);
      check($sformatf("stall h%0d ready0", i), {31'd0, req0_ready}, 32'd0);
      @(negedge clk);
    end
    rsp1_ready = 1'b1;
    #1;
    check("stall release ready0", {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    rsp1_ready = 1'b0;
    #1;
    check("stall done rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("stall next grant0", {31'd0, req0_ready}, 32'd1);

    // Reset arriving in the middle of EXEC
    @(negedge clk);
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 9'd0);
    #1;
    check("abort exec alu1", alu1_data, 32'd1);
    check("abort exec state", {30'd0, state_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort async state", {30'd0, state_o}, 32'd0);
    check("abort async alu", alu1_data | alu2_data, 32'd0);
    check("abort async readys", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("abort post c%0d rsp", i), {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      @(negedge clk);
    end
    set_req(1'b0, 1'b1, 32'd4, 32'd4, OP_ADD);
    set_req(1'b1, 1'b1, 32'd4, 32'd4, OP_ADD);
    #1;
    check("abort regrant ptr", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(negedge clk);
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 9'd0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 9'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
